// File: rtl/pipe_ctrl_unit.sv
// ID-stage control for the pipelined LEGv8 core: opcode decode, branch resolution in ID,
// NZCV register with EX forwarding, load-use stall detection and the ID/EX control register.
module pipe_ctrl_unit #(
    parameter int DATA_W     = 64,
    parameter int XFER_BYTES = 8,
    parameter int COND_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [10:0]       id_opcode,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic [DATA_W-1:0] id_da,
    input  logic [3:0]        ex_alu_flags,
    input  logic              flush,
    output logic              stall,
    output logic              br_taken,
    output logic              uncond_br,
    output logic              br_reg,
    output logic              squash_if,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_flagset,
    output logic              ex_bl,
    output logic              ex_immediate,
    output logic [2:0]        ex_aluop,
    output logic [3:0]        ex_xfer_size,
    output logic [4:0]        ex_rd,
    output logic [3:0]        flags_q
);

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       flagset;
        logic       bl;
        logic       immediate;
        logic [2:0] aluop;
        logic [3:0] xfer;
        logic [4:0] rd;
    } ctrl_t;

    ctrl_t      dec_w;
    ctrl_t      ex_d;
    ctrl_t      ex_q;
    logic       use_rn;
    logic       use_src2;
    logic [4:0] src2;
    logic       is_b;
    logic       is_bl;
    logic       is_br;
    logic       is_cbz;
    logic       is_bcond;
    logic [3:0] eff_flags;
    logic       cond_met;
    logic       taken_raw;
    logic       unused_c_flag;

    always_comb begin
        dec_w    = '0;
        use_rn   = 1'b0;
        use_src2 = 1'b0;
        src2     = id_rm;
        is_b     = 1'b0;
        is_bl    = 1'b0;
        is_br    = 1'b0;
        is_cbz   = 1'b0;
        is_bcond = 1'b0;
        if (id_valid) begin
            casez (id_opcode)
                11'b1001000100?: begin
                    dec_w.valid     = 1'b1;
                    dec_w.regwrite  = (id_rd != 5'd31);
                    dec_w.alusrc    = 1'b1;
                    dec_w.immediate = 1'b1;
                    dec_w.aluop     = ALU_ADD;
                    dec_w.rd        = id_rd;
                    use_rn          = 1'b1;
                end
                11'b10101011000, 11'b11101011000: begin
                    dec_w.valid    = 1'b1;
                    dec_w.regwrite = (id_rd != 5'd31);
                    dec_w.flagset  = 1'b1;
                    dec_w.aluop    = id_opcode[9] ? ALU_SUB : ALU_ADD;
                    dec_w.rd       = id_rd;
                    use_rn         = 1'b1;
                    use_src2       = 1'b1;
                end
                11'b11111000010: begin
                    dec_w.valid    = 1'b1;
                    dec_w.regwrite = (id_rd != 5'd31);
                    dec_w.memread  = 1'b1;
                    dec_w.memtoreg = 1'b1;
                    dec_w.alusrc   = 1'b1;
                    dec_w.aluop    = ALU_ADD;
                    dec_w.xfer     = 4'(XFER_BYTES);
                    dec_w.rd       = id_rd;
                    use_rn         = 1'b1;
                end
                11'b11111000000: begin
                    dec_w.valid    = 1'b1;
                    dec_w.memwrite = 1'b1;
                    dec_w.alusrc   = 1'b1;
                    dec_w.aluop    = ALU_ADD;
                    dec_w.xfer     = 4'(XFER_BYTES);
                    dec_w.rd       = id_rd;
                    use_rn         = 1'b1;
                    use_src2       = 1'b1;
                    src2           = id_rd;
                end
                11'b000101?????: begin
                    dec_w.valid = 1'b1;
                    is_b        = 1'b1;
                end
                11'b100101?????: begin
                    dec_w.valid    = 1'b1;
                    dec_w.bl       = 1'b1;
                    dec_w.regwrite = 1'b1;
                    dec_w.rd       = 5'd30;
                    is_bl          = 1'b1;
                end
                11'b11010110000: begin
                    dec_w.valid = 1'b1;
                    is_br       = 1'b1;
                    use_src2    = 1'b1;
                    src2        = id_rd;
                end
                11'b10110100???: begin
                    dec_w.valid = 1'b1;
                    dec_w.aluop = ALU_PASSB;
                    is_cbz      = 1'b1;
                    use_src2    = 1'b1;
                    src2        = id_rd;
                end
                11'b01010100???: begin
                    dec_w.valid = 1'b1;
                    is_bcond    = 1'b1;
                end
                default: dec_w = '0;
            endcase
        end
    end

    // A load still in EX cannot forward its data in time for a consumer in ID.
    assign stall = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd31) &&
                   ((use_rn && (id_rn == ex_q.rd)) || (use_src2 && (src2 == ex_q.rd)));

    assign eff_flags     = (ex_q.valid && ex_q.flagset) ? ex_alu_flags : flags_q;
    assign unused_c_flag = eff_flags[1];

    // eff_flags = {N, Z, C, V}
    always_comb begin
        cond_met = 1'b0;
        if (COND_EN == 0) begin
            cond_met = (eff_flags[3] != eff_flags[0]);
        end else begin
            case (id_rd[3:0])
                4'b0000: cond_met = eff_flags[2];
                4'b0001: cond_met = !eff_flags[2];
                4'b1010: cond_met = (eff_flags[3] == eff_flags[0]);
                4'b1011: cond_met = (eff_flags[3] != eff_flags[0]);
                4'b1100: cond_met = !eff_flags[2] && (eff_flags[3] == eff_flags[0]);
                4'b1101: cond_met = eff_flags[2] || (eff_flags[3] != eff_flags[0]);
                4'b1110: cond_met = 1'b1;
                default: cond_met = 1'b0;
            endcase
        end
    end

    assign taken_raw = is_b || is_bl || (is_cbz && (id_da == '0)) || (is_bcond && cond_met);
    assign br_taken  = taken_raw && !stall;
    assign br_reg    = is_br && !stall;
    assign squash_if = br_taken || br_reg;
    assign uncond_br = is_b || is_bl;

    assign ex_d = (flush || stall) ? '0 : dec_w;

    // The EX instruction completes regardless of stall/flush, so its flags always commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            flags_q <= 4'b0000;
        end else begin
            ex_q <= ex_d;
            if (ex_q.valid && ex_q.flagset) begin
                flags_q <= ex_alu_flags;
            end
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_memread   = ex_q.memread;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_flagset   = ex_q.flagset;
    assign ex_bl        = ex_q.bl;
    assign ex_immediate = ex_q.immediate;
    assign ex_aluop     = ex_q.aluop;
    assign ex_xfer_size = ex_q.xfer;
    assign ex_rd        = ex_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed and randomized checks of pipe_ctrl_unit against an instruction-level model
// (kind of instruction held in EX plus architectural flags).
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [10:0] id_opcode;
    logic [4:0]  id_rd, id_rn, id_rm;
    logic [63:0] id_da;
    logic [3:0]  ex_alu_flags;
    logic        flush;

    logic stall, br_taken, uncond_br, br_reg, squash_if;
    logic ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_flagset, ex_bl, ex_immediate;
    logic [2:0] ex_aluop;
    logic [3:0] ex_xfer_size;
    logic [4:0] ex_rd;
    logic [3:0] flags_q;

    logic u1_stall, u1_br_taken, u1_uncond_br, u1_br_reg, u1_squash_if;
    logic u1_ex_valid, u1_ex_regwrite, u1_ex_memread, u1_ex_memwrite, u1_ex_memtoreg, u1_ex_alusrc;
    logic u1_ex_flagset, u1_ex_bl, u1_ex_immediate;
    logic [2:0] u1_ex_aluop;
    logic [3:0] u1_ex_xfer_size;
    logic [4:0] u1_ex_rd;
    logic [3:0] u1_flags_q;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.DATA_W(64), .XFER_BYTES(8), .COND_EN(1)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_da(id_da),
        .ex_alu_flags(ex_alu_flags), .flush(flush),
        .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br), .br_reg(br_reg), .squash_if(squash_if),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_flagset(ex_flagset), .ex_bl(ex_bl),
        .ex_immediate(ex_immediate), .ex_aluop(ex_aluop), .ex_xfer_size(ex_xfer_size), .ex_rd(ex_rd),
        .flags_q(flags_q)
    );

    pipe_ctrl_unit #(.DATA_W(64), .XFER_BYTES(8), .COND_EN(0)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_da(id_da),
        .ex_alu_flags(ex_alu_flags), .flush(flush),
        .stall(u1_stall), .br_taken(u1_br_taken), .uncond_br(u1_uncond_br), .br_reg(u1_br_reg),
        .squash_if(u1_squash_if), .ex_valid(u1_ex_valid), .ex_regwrite(u1_ex_regwrite),
        .ex_memread(u1_ex_memread), .ex_memwrite(u1_ex_memwrite), .ex_memtoreg(u1_ex_memtoreg),
        .ex_alusrc(u1_ex_alusrc), .ex_flagset(u1_ex_flagset), .ex_bl(u1_ex_bl),
        .ex_immediate(u1_ex_immediate), .ex_aluop(u1_ex_aluop), .ex_xfer_size(u1_ex_xfer_size),
        .ex_rd(u1_ex_rd), .flags_q(u1_flags_q)
    );

    typedef enum int {K_UNDEF, K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_B, K_BL, K_BR, K_CBZ, K_BCOND} kind_e;

    int tests = 0;
    int fails = 0;

    // Model: what instruction sits in EX, its destination, and the architectural flags.
    logic       m_valid;
    kind_e      m_kind;
    logic [4:0] m_rd;
    logic [3:0] m_flags;

    logic obs_stall, obs_taken, obs_squash, obs_leg;

    function automatic kind_e classify(input logic [10:0] op);
        if (op[10:1] == 10'b1001000100) return K_ADDI;
        if (op == 11'b10101011000)      return K_ADDS;
        if (op == 11'b11101011000)      return K_SUBS;
        if (op == 11'b11111000010)      return K_LDUR;
        if (op == 11'b11111000000)      return K_STUR;
        if (op[10:5] == 6'b000101)      return K_B;
        if (op[10:5] == 6'b100101)      return K_BL;
        if (op == 11'b11010110000)      return K_BR;
        if (op[10:3] == 8'b10110100)    return K_CBZ;
        if (op[10:3] == 8'b01010100)    return K_BCOND;
        return K_UNDEF;
    endfunction

    function automatic logic [10:0] op_of(input kind_e k);
        logic [4:0] r;
        r = 5'($urandom_range(31));
        case (k)
            K_ADDI:  return {10'b1001000100, r[0]};
            K_ADDS:  return 11'b10101011000;
            K_SUBS:  return 11'b11101011000;
            K_LDUR:  return 11'b11111000010;
            K_STUR:  return 11'b11111000000;
            K_B:     return {6'b000101, r};
            K_BL:    return {6'b100101, r};
            K_BR:    return 11'b11010110000;
            K_CBZ:   return {8'b10110100, r[2:0]};
            K_BCOND: return {8'b01010100, r[2:0]};
            default: return r[0] ? 11'h7FF : 11'h000;
        endcase
    endfunction

    // f = {N, Z, C, V}
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ex();
        logic [16:0] exp_ctrl;
        logic [2:0]  aluop;
        kind_e k;
        k = m_valid ? m_kind : K_UNDEF;
        aluop = (k == K_SUBS) ? 3'b011 :
                (k inside {K_ADDI, K_ADDS, K_LDUR, K_STUR}) ? 3'b010 : 3'b000;
        exp_ctrl = {m_valid, k == K_LDUR, k == K_STUR, k == K_LDUR,
                    k inside {K_ADDI, K_LDUR, K_STUR}, k inside {K_ADDS, K_SUBS},
                    k == K_BL, k == K_ADDI, aluop,
                    (k inside {K_LDUR, K_STUR}) ? 4'd8 : 4'd0, 2'b00};
        check("ex_ctrl", {ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_flagset,
                          ex_bl, ex_immediate, ex_aluop, ex_xfer_size, 2'b00}, exp_ctrl);
        if (!(k inside {K_ADDS, K_SUBS, K_LDUR}))
            check("ex_regwrite", ex_regwrite, (k == K_ADDI && m_rd != 5'd31) || k == K_BL);
        if (k inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_BL})
            check("ex_rd", ex_rd, m_rd);
        check("flags_q", flags_q, m_flags);
        check("u1_ex_valid", u1_ex_valid, m_valid);
    endtask

    task automatic run_cycle();
        kind_e      k;
        logic       use1, use2, st, tk, tk_leg;
        logic [4:0] s2;
        logic [3:0] ef;
        logic [4:0] exp_comb;
        k    = id_valid ? classify(id_opcode) : K_UNDEF;
        use1 = k inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR};
        use2 = k inside {K_ADDS, K_SUBS, K_STUR, K_CBZ, K_BR};
        s2   = (k inside {K_ADDS, K_SUBS}) ? id_rm : id_rd;
        st   = m_valid && m_kind == K_LDUR && m_rd != 5'd31 &&
               ((use1 && id_rn == m_rd) || (use2 && s2 == m_rd));
        ef   = (m_valid && m_kind inside {K_ADDS, K_SUBS}) ? ex_alu_flags : m_flags;
        tk     = !st && (k == K_B || k == K_BL || (k == K_CBZ && id_da == 64'd0) ||
                         (k == K_BCOND && cond_ok(id_rd[3:0], ef)));
        tk_leg = !st && (k == K_B || k == K_BL || (k == K_CBZ && id_da == 64'd0) ||
                         (k == K_BCOND && ef[3] != ef[0]));
        exp_comb = {st, tk, k == K_B || k == K_BL, !st && k == K_BR, tk || (!st && k == K_BR)};
        @(negedge clk);
        obs_stall  = stall;
        obs_taken  = br_taken;
        obs_squash = squash_if;
        obs_leg    = u1_br_taken;
        check("comb", {stall, br_taken, uncond_br, br_reg, squash_if}, exp_comb);
        check("legacy_taken", u1_br_taken, tk_leg);
        @(posedge clk);
        if (m_valid && m_kind inside {K_ADDS, K_SUBS}) m_flags = ex_alu_flags;
        if (flush || st || k == K_UNDEF) begin
            m_valid = 1'b0; m_kind = K_UNDEF; m_rd = 5'd0;
        end else begin
            m_valid = 1'b1; m_kind = k; m_rd = (k == K_BL) ? 5'd30 : id_rd;
        end
        #1;
        check_ex();
        $display("[TB] t=%0t op=%b rd=%0d rn=%0d rm=%0d flush=%0b stall=%0b taken=%0b ex_valid=%0b flags=%b",
                 $time, id_opcode, id_rd, id_rn, id_rm, flush, obs_stall, obs_taken, ex_valid, flags_q);
    endtask

    task automatic set_id(input kind_e k, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        id_valid  = 1'b1;
        id_opcode = op_of(k);
        id_rd = rd; id_rn = rn; id_rm = rm;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rn = '0; id_rm = '0;
        id_da = '0; ex_alu_flags = 4'b0000; flush = 1'b0;
        m_valid = 1'b0; m_kind = K_UNDEF; m_rd = '0; m_flags = '0;
        @(posedge clk); @(posedge clk); #1;
        check_ex();
        check("reset_stall", stall, 1'b0);
        reset = 1'b0;

        // ADDI to XZR, then to X5
        set_id(K_ADDI, 5'd31, 5'd1, 5'd0); run_cycle();
        check("addi31_regwrite", ex_regwrite, 1'b0);
        set_id(K_ADDI, 5'd5, 5'd1, 5'd0); run_cycle();
        check("addi5_regwrite", ex_regwrite, 1'b1);
        check("addi_aluop", ex_aluop, 3'b010);
        check("addi_alusrc", ex_alusrc, 1'b1);

        // load-use: LDUR X3 then ADDS using X3
        set_id(K_LDUR, 5'd3, 5'd1, 5'd0); run_cycle();
        set_id(K_ADDS, 5'd6, 5'd3, 5'd2); run_cycle();
        check("lu_stall", obs_stall, 1'b1);
        check("lu_bubble", ex_valid, 1'b0);
        run_cycle();
        check("lu_nostall", obs_stall, 1'b0);
        check("lu_adds_in_ex", {ex_valid, ex_flagset}, 2'b11);

        // CBZ
        set_id(K_CBZ, 5'd2, 5'd0, 5'd0); id_da = 64'd0; run_cycle();
        check("cbz0_taken", {obs_taken, obs_squash}, 2'b11);
        id_da = 64'h1; run_cycle();
        check("cbz1_taken", obs_taken, 1'b0);
        id_da = 64'd0;

        // establish Z=1 in flags_q, then B.EQ / B.NE / cond 0111
        set_id(K_SUBS, 5'd7, 5'd1, 5'd2); run_cycle();
        id_valid = 1'b0; ex_alu_flags = 4'b0100; run_cycle();
        check("z_flags", flags_q, 4'b0100);
        ex_alu_flags = 4'b0000;
        set_id(K_BCOND, 5'b00000, 5'd0, 5'd0); run_cycle();
        check("beq_taken", obs_taken, 1'b1);
        set_id(K_BCOND, 5'b00001, 5'd0, 5'd0); run_cycle();
        check("bne_taken", obs_taken, 1'b0);
        set_id(K_BCOND, 5'b00111, 5'd0, 5'd0); run_cycle();
        check("b0111_taken", obs_taken, 1'b0);

        // SUBS in EX forwards N=1 to B.LT in ID
        set_id(K_SUBS, 5'd8, 5'd1, 5'd2); run_cycle();
        set_id(K_BCOND, 5'b01011, 5'd0, 5'd0); ex_alu_flags = 4'b1000; run_cycle();
        check("blt_fwd_taken", obs_taken, 1'b1);
        check("blt_flags", flags_q, 4'b1000);
        ex_alu_flags = 4'b0000;
        set_id(K_BCOND, 5'b00000, 5'd0, 5'd0); run_cycle();
        check("legacy_beq", {obs_leg, obs_taken}, 2'b10);

        // BL
        set_id(K_BL, 5'd9, 5'd0, 5'd0); run_cycle();
        check("bl_word", {ex_rd, ex_bl}, {5'd30, 1'b1});

        // flush squashes; flags still commit; flush with stall keeps stall
        set_id(K_SUBS, 5'd4, 5'd1, 5'd2); run_cycle();
        set_id(K_ADDI, 5'd4, 5'd1, 5'd0); flush = 1'b1; ex_alu_flags = 4'b0011; run_cycle();
        check("flush_bubble", ex_valid, 1'b0);
        check("flush_flags", flags_q, 4'b0011);
        flush = 1'b0;
        set_id(K_LDUR, 5'd7, 5'd1, 5'd0); run_cycle();
        set_id(K_STUR, 5'd7, 5'd2, 5'd0); flush = 1'b1; run_cycle();
        check("flush_stall", {obs_stall, ex_valid}, 2'b10);
        flush = 1'b0;

        // reset while a stall is showing
        set_id(K_LDUR, 5'd4, 5'd0, 5'd0); run_cycle();
        set_id(K_ADDS, 5'd6, 5'd4, 5'd1);
        @(negedge clk);
        check("pre_reset_stall", stall, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_ex", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
                         ex_flagset, ex_bl, ex_immediate, ex_aluop, ex_xfer_size, ex_rd}, 64'd0);
        check("rst_flags", flags_q, 4'b0000);
        check("rst_stall", stall, 1'b0);
        m_valid = 1'b0; m_kind = K_UNDEF; m_rd = '0; m_flags = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            set_id(kind_e'($urandom_range(10)), pick_reg(), pick_reg(), pick_reg());
            if (id_opcode[10:3] == 8'b01010100) id_rd = 5'($urandom_range(31));
            id_valid     = ($urandom_range(7) != 0);
            id_da        = ($urandom_range(2) == 0) ? 64'd0 : {$urandom, $urandom};
            ex_alu_flags = 4'($urandom_range(15));
            flush        = ($urandom_range(9) == 0);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
